// File: rtl/counter_display_pkg.sv
// Shared types and constants for the counter display: converter states,
// active-low seven-segment codes ({g,f,e,d,c,b,a}) and double-dabble helpers.
package counter_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] AN_RESET  = 3'b110;
  localparam logic [2:0] AN_TENS   = 3'b101;
  localparam logic [2:0] AN_HUNDS  = 3'b011;

  localparam int SHIFT_CYCLES = 8;

  // Non-decimal nibbles cannot occur; they fall back to a dark digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [11:0] dabble(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter using double-dabble,
// one bit per cycle on a fixed 10-cycle IDLE/SHIFT x8/LOAD schedule.
module bin2bcd_seq
  import counter_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic [11:0] bcd
);

  conv_state_t state, state_next;
  logic [2:0]  shift_cnt;
  logic [7:0]  bin_sr;
  logic [11:0] acc;
  logic [11:0] acc_adj;
  logic [19:0] shifted;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = SHIFT;
      SHIFT:   if (shift_cnt == 3'(SHIFT_CYCLES - 1)) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Adjust nibbles first, then shift the binary MSB into the BCD accumulator.
  assign acc_adj = dabble(acc);
  assign shifted = {acc_adj, bin_sr} << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_cnt <= 3'd0;
      bin_sr    <= 8'd0;
      acc       <= 12'd0;
      bcd       <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          bin_sr    <= value;
          acc       <= 12'd0;
          shift_cnt <= 3'd0;
        end
        SHIFT: begin
          acc       <= shifted[19:8];
          bin_sr    <= shifted[7:0];
          shift_cnt <= shift_cnt + 3'd1;
        end
        LOAD: bcd <= acc;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/counter_display.sv
// Three-digit multiplexed seven-segment driver for an 8-bit count.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros in hundreds/tens.
module counter_display
  import counter_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] refresh_cnt;
  logic          refresh_tc;
  logic [1:0]    digit_idx;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg_next;
  logic [2:0]    an_next;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .bcd   (bcd)
  );

  assign refresh_tc = (refresh_cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else if (refresh_tc) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  // Digit select reads bcd live, so a new conversion shows up mid-slot.
  always_comb begin
    digit   = bcd[3:0];
    an_next = AN_RESET;
    blank   = 1'b0;
    case (digit_idx)
      2'd1: begin
        digit   = bcd[7:4];
        an_next = AN_TENS;
`ifdef LEADING_ZERO_BLANK_EN
        blank   = (bcd[11:4] == 8'd0);
`endif
      end
      2'd2: begin
        digit   = bcd[11:8];
        an_next = AN_HUNDS;
`ifdef LEADING_ZERO_BLANK_EN
        blank   = (bcd[11:8] == 4'd0);
`endif
      end
      default: ;
    endcase
    seg_next = blank ? SEG_BLANK : seg_decode(digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_RESET;
      seg <= SEG_0;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_counter_display.sv
// Directed self-checking bench for counter_display with REFRESH_DIV=4.
// Build with or without LEADING_ZERO_BLANK_EN; expectations follow the macro.
module tb_counter_display;

  localparam int REFRESH_DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  value;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  an;

  int errors = 0;
  int checks = 0;
  int k      = 0;
  int next_k = 0;

  counter_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .bcd   (bcd),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s (k=%0d): got 0x%0h, expected 0x%0h", tag, k, obs, exp);
    end
  endtask

  // k is the index of the edge just taken, counted from the first edge with reset low.
  task automatic applyStimulus(input logic r, input logic [7:0] v);
    reset = r;
    value = v;
    @(posedge clk);
    #1;
    if (r) begin
      next_k = 0;
    end else begin
      k = next_k;
      next_k++;
    end
  endtask

  // Outputs after edge k reflect the digit index held before edge k: floor(k/4) mod 3.
  task automatic checkDisplay(input string tag, input logic [6:0] su, input logic [6:0] st,
                              input logic [6:0] sh);
    int idx;
    idx = (k / REFRESH_DIV) % 3;
    case (idx)
      0: begin checkOutput({tag, ".an"}, an, 3'b110); checkOutput({tag, ".seg_u"}, seg, su); end
      1: begin checkOutput({tag, ".an"}, an, 3'b101); checkOutput({tag, ".seg_t"}, seg, st); end
      default: begin checkOutput({tag, ".an"}, an, 3'b011); checkOutput({tag, ".seg_h"}, seg, sh); end
    endcase
  endtask

  task automatic runValue(input string tag, input logic [7:0] v, input int n,
                          input logic [6:0] su, input logic [6:0] st, input logic [6:0] sh,
                          input logic [11:0] eb);
    applyStimulus(1'b1, v);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, v);
      if (k < 10) checkDisplay(tag, 7'h40, LZ, LZ);
      else        checkDisplay(tag, su, st, sh);
      if (k == 8) checkOutput({tag, ".bcd_pre"}, bcd, 12'h000);
      if (k == 9) checkOutput({tag, ".bcd"}, bcd, eb);
    end
    checkOutput({tag, ".bcd_end"}, bcd, eb);
  endtask

  initial begin
    reset = 1'b1;
    value = 8'd0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'd77);
      checkOutput("reset.bcd", bcd, 12'h000);
      checkOutput("reset.an", an, 3'b110);
      checkOutput("reset.seg", seg, 7'h40);
    end

    runValue("full",  8'd255, 30, 7'h12, 7'h12, 7'h24, 12'h255);
    runValue("blank", 8'd7,   30, 7'h78, LZ,    LZ,    12'h007);
    runValue("inner", 8'd105, 30, 7'h12, 7'h40, 7'h79, 12'h105);
    runValue("hund",  8'd100, 30, 7'h40, 7'h40, 7'h79, 12'h100);
    runValue("zero",  8'd0,   30, 7'h40, LZ,    LZ,    12'h000);

    applyStimulus(1'b1, 8'd9);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, (next_k >= 3) ? 8'd10 : 8'd9);
      if (k == 9)  checkOutput("midchg.first", bcd, 12'h009);
      if (k == 18) checkOutput("midchg.hold", bcd, 12'h009);
      if (k == 19) checkOutput("midchg.second", bcd, 12'h010);
    end

    applyStimulus(1'b1, 8'd200);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'd200);
    applyStimulus(1'b1, 8'd200);
    checkOutput("rstmid.bcd", bcd, 12'h000);
    checkOutput("rstmid.an", an, 3'b110);
    checkOutput("rstmid.seg", seg, 7'h40);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'd200);
      if (k == 8) checkOutput("rstmid.bcd_pre", bcd, 12'h000);
      if (k == 9) checkOutput("rstmid.bcd_post", bcd, 12'h200);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_display.md
COUNTER_DISPLAY -- requirements
Module: counter_display

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, port reset.
REQ-002 Parameter REFRESH_DIV SHALL default to 50000: clk cycles per digit slot, legal range 2..2^20.
REQ-003 Port clk SHALL be: input, 1 bit, rising-edge clock.
REQ-004 Port reset SHALL be: input, 1 bit, synchronous active-high reset.
REQ-005 Port value SHALL be: input [7:0], unsigned binary count, e.g. from the 8-bit counter out.
REQ-006 Port bcd SHALL be: output [11:0], {hundreds, tens, units} of the last completed conversion.
REQ-007 Port seg SHALL be: output [6:0], {g,f,e,d,c,b,a}, active-low.
REQ-008 Port an SHALL be: output [2:0], active-low digit enables; an[0] drives units, an[2] drives hundreds.

Function
REQ-009 The converter FSM SHALL cycle IDLE -> SHIFT (exactly 8 cycles) -> LOAD -> IDLE, for a 10-cycle period, with no stall states.
REQ-010 The FSM SHALL sample value in IDLE; changes to value during SHIFT or LOAD SHALL be ignored until the next IDLE.
REQ-011 Each SHIFT cycle SHALL use double-dabble: add 3 to each BCD nibble >= 5, then shift left 1 bit, with the value MSB entering first.
REQ-012 LOAD SHALL update bcd so that it is valid 10 cycles after the IDLE sample; worst-case latency from a value change to bcd is 19 cycles.
REQ-013 Conversion SHALL be exact for 0..255: 255 -> 12'h255, 0 -> 12'h000, 100 -> 12'h100; no intermediate nibble exceeds 9.
REQ-014 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count the digit index SHALL advance 0 -> 1 -> 2 -> 0.
REQ-015 seg and an SHALL be registered: each reflects the index and bcd of the previous cycle.
REQ-016 an SHALL be one-hot-low for the index: 110, 101 or 011; any other pattern is illegal.
REQ-017 Segment codes SHALL be: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, blank=0x7F.
REQ-018 If bcd changes mid-slot, seg SHALL show the new digit on the next cycle without restarting the slot.

Reset
REQ-019 reset SHALL take priority over all activity, including a conversion in progress, and abort it.
REQ-020 On the cycle after reset is sampled high, the block SHALL hold: FSM=IDLE, bcd=12'h000, shift register=0, refresh counter=0, index=0, an=110, seg=0x40.
REQ-021 After reset releases, the first IDLE sample SHALL occur on the first cycle with reset low.

Configuration
REQ-022 With macro LEADING_ZERO_BLANK_EN defined, the block SHALL drive seg=0x7F (blank) for the hundreds digit when it is 0, and for the tens digit when both hundreds and tens are 0.
REQ-023 With LEADING_ZERO_BLANK_EN defined, the units digit SHALL never be blanked.
REQ-024 Without LEADING_ZERO_BLANK_EN, the block SHALL show every digit, including leading zeros.
REQ-025 an timing SHALL be identical with and without LEADING_ZERO_BLANK_EN.

Structure
REQ-026 Package counter_display_pkg SHALL hold the FSM state enum (IDLE/SHIFT/LOAD), the ten digit segment constants, SEG_BLANK and AN_RESET.
REQ-027 Sub-module bin2bcd_seq SHALL implement REQ-009..REQ-013, with ports clk, reset, value, bcd; counter_display SHALL contain the refresh, mux and decode logic.

Verification (benches use REFRESH_DIV=4)
REQ-028 Reset test: assert reset 3 cycles with value=8'd77 -> bcd=12'h000, an=110, seg=0x40 throughout.
REQ-029 Full-scale test: value=8'd255 held 30 cycles -> bcd=12'h255 by cycle 19; an cycles 110/101/011 every 4 cycles; seg is 0x12, 0x12, 0x24 respectively.
REQ-030 Blanking test: value=8'd7 -> with LEADING_ZERO_BLANK_EN, hundreds and tens seg=0x7F and units seg=0x78; without the macro, the three digits are 0x40, 0x40, 0x78.
REQ-031 Inner-zero test: value=8'd105 with LEADING_ZERO_BLANK_EN -> tens digit shows 0x40, not blank; bcd=12'h105.
REQ-032 Mid-conversion change: value changes 9 -> 10 on the 3rd SHIFT cycle -> that LOAD gives bcd=12'h009 and the following LOAD gives bcd=12'h010.
REQ-033 Reset mid-conversion: assert reset during SHIFT with value=8'd200 -> next cycle FSM=IDLE, bcd=12'h000, an=110; after release, bcd=12'h200 within 10 cycles.
